// File: rtl/byte_queue_if.sv
// Purpose: handshake bundle between the deserializer, the byte queue and its consumer.
// Signals:
//   data_in/data_ready/ack_out : enqueue handshake with the deserializer
//   dequeue_in                 : consumer pop request
//   data_out/valid_out         : popped byte and its one-cycle strobe
//   len_out/full_out/empty_out : occupancy status
// Modports: master = producer/consumer side, slave = queue side.
interface byte_queue_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned LEN_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] data_in;
    logic              data_ready;
    logic              ack_out;
    logic              dequeue_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [LEN_W-1:0]  len_out;
    logic              full_out;
    logic              empty_out;

    modport master (
        output data_in, data_ready, dequeue_in,
        input  ack_out, data_out, valid_out, len_out, full_out, empty_out
    );

    modport slave (
        input  data_in, data_ready, dequeue_in,
        output ack_out, data_out, valid_out, len_out, full_out, empty_out
    );
endinterface

// File: rtl/byte_queue.sv
// Purpose: byte FIFO behind the deserializer. Captures each byte offered on
// data_ready, acknowledges it with a one-cycle ack_out pulse, withholds the
// ack while full, and pops one byte per dequeue_in request.
// Ports:
//   clk_100KHz : system clock, rising edge
//   reset      : asynchronous, active-low
//   bus        : byte_queue_if slave (handshake, output byte, occupancy)
module byte_queue #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic         clk_100KHz,
    input  logic         reset,
    byte_queue_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LEN_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [LEN_W-1:0]  len_q;
    logic              ack_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              full_q;
    logic              empty_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_en;
    logic              rd_en;
    logic [LEN_W-1:0]  len_nxt;

    // Write/read qualification on pre-edge status; occupancy update.
    always_comb begin
        wr_en   = (state == S_IDLE) && bus.data_ready && !full_q;
        rd_en   = bus.dequeue_in && !empty_q;
        len_nxt = len_q;
        if (wr_en && !rd_en) begin
            len_nxt = len_q + LEN_W'(1);
        end else if (rd_en && !wr_en) begin
            len_nxt = len_q - LEN_W'(1);
        end
    end

    // Storage has no reset; contents are meaningless until written.
    always_ff @(posedge clk_100KHz) begin
        if (wr_en) begin
            mem[tail] <= bus.data_in;
        end
    end

    // Enqueue FSM, read port and status registers.
    always_ff @(posedge clk_100KHz or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            head    <= '0;
            tail    <= '0;
            len_q   <= '0;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            ack_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_en) begin
                        tail  <= tail + PTR_W'(1);
                        ack_q <= 1'b1;
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A byte left on data_ready after its ack is never taken twice.
                    if (!bus.data_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            valid_q <= rd_en;
            if (rd_en) begin
                data_q <= mem[head];
                head   <= head + PTR_W'(1);
            end

            len_q   <= len_nxt;
            full_q  <= (len_nxt == LEN_W'(DEPTH));
            empty_q <= (len_nxt == '0);
        end
    end

    assign bus.ack_out   = ack_q;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
    assign bus.len_out   = len_q;
    assign bus.full_out  = full_q;
    assign bus.empty_out = empty_q;
endmodule

// File: tb/tb_byte_queue.sv
// Purpose: self-checking bench for byte_queue. A driver issues pushes and pops;
// each pushed byte is queued as an expected output. A negedge monitor keeps an
// occupancy count and pops/compares the expected byte on every valid_out.
module tb_byte_queue;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 8;

    logic clk_100KHz = 1'b0;
    logic reset;

    always #5 clk_100KHz = ~clk_100KHz;

    byte_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus();

    byte_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_100KHz (clk_100KHz),
        .reset      (reset),
        .bus        (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] sb[$];
    int         mlen = 0;
    bit         pending = 1'b0;
    logic [7:0] last_out = 8'h00;
    logic       rdy_s, deq_s;
    bit         ea, ev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs as seen by the DUT at each rising edge.
    always @(posedge clk_100KHz) begin
        rdy_s <= bus.data_ready;
        deq_s <= bus.dequeue_in;
    end

    // Monitor: reference model of a bounded FIFO with one ack per offered byte.
    always @(negedge clk_100KHz) begin
        if (!reset) begin
            chk("rst_ack", bus.ack_out, 0);
            chk("rst_valid", bus.valid_out, 0);
            chk("rst_len", bus.len_out, 0);
            chk("rst_empty", bus.empty_out, 1);
            chk("rst_full", bus.full_out, 0);
            chk("rst_data", bus.data_out, 0);
            sb.delete();
            mlen     = 0;
            pending  = 1'b0;
            last_out = 8'h00;
        end else begin
            ea = rdy_s && pending && (mlen != DEPTH);
            ev = deq_s && (mlen != 0);
            chk("ack", bus.ack_out, ea);
            chk("valid", bus.valid_out, ev);
            if (ea) begin
                pending = 1'b0;
                mlen++;
            end
            if (ev) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got valid_out with no expected byte at %0t", $time);
                end else begin
                    last_out = sb.pop_front();
                end
                mlen--;
            end
            chk("data", bus.data_out, last_out);
            chk("len", bus.len_out, mlen);
            chk("full", bus.full_out, mlen == DEPTH);
            chk("empty", bus.empty_out, mlen == 0);
        end
    end

    task automatic tick();
        @(posedge clk_100KHz);
        #1;
    endtask

    task automatic start_push(input logic [7:0] b);
        bus.data_in    = b;
        bus.data_ready = 1'b1;
        pending        = 1'b1;
        sb.push_back(b);
    endtask

    // Wait (bounded) for the ack, then drop data_ready long enough to re-arm.
    task automatic wait_ack();
        int n = 0;
        while (!bus.ack_out && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (!bus.ack_out) begin
            bad++;
            $display("FAIL ack_timeout: got no ack_out within %0d cycles", n);
        end
        bus.data_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic push(input logic [7:0] b);
        start_push(b);
        wait_ack();
    endtask

    initial begin
        int nv;
        int len_before;
        logic [7:0] b;

        // Reset held with random inputs.
        reset          = 1'b0;
        bus.data_in    = 8'h00;
        bus.data_ready = 1'b0;
        bus.dequeue_in = 1'b0;
        repeat (5) begin
            bus.data_in    = 8'($urandom);
            bus.data_ready = 1'($urandom);
            bus.dequeue_in = 1'($urandom);
            tick();
        end
        bus.data_ready = 1'b0;
        bus.dequeue_in = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Single byte, data_ready held long after the ack.
        start_push(8'hA5);
        tick();
        chk("t2_ack", bus.ack_out, 1);
        chk("t2_len", bus.len_out, 1);
        repeat (3) tick();
        bus.data_ready = 1'b0;
        tick();
        tick();
        chk("t2_len_hold", bus.len_out, 1);
        bus.dequeue_in = 1'b1;
        tick();
        bus.dequeue_in = 1'b0;
        chk("t2_valid", bus.valid_out, 1);
        chk("t2_data", bus.data_out, 8'hA5);
        chk("t2_len0", bus.len_out, 0);

        // Fill, then offer one more while full.
        for (int i = 1; i <= 8; i++) push(8'(i));
        chk("t3_full", bus.full_out, 1);
        chk("t3_len", bus.len_out, 8);
        start_push(8'h09);
        repeat (3) begin
            tick();
            chk("t3_noack", bus.ack_out, 0);
        end
        bus.dequeue_in = 1'b1;
        tick();
        bus.dequeue_in = 1'b0;
        chk("t3_valid", bus.valid_out, 1);
        chk("t3_data", bus.data_out, 8'h01);
        chk("t3_ack_wait", bus.ack_out, 0);
        tick();
        chk("t3_ack_late", bus.ack_out, 1);
        chk("t3_full_again", bus.full_out, 1);
        bus.data_ready = 1'b0;
        tick();
        tick();

        // Drain with dequeue held high.
        nv = 0;
        bus.dequeue_in = 1'b1;
        repeat (10) begin
            tick();
            if (bus.valid_out) nv++;
        end
        bus.dequeue_in = 1'b0;
        chk("t4_pulses", nv, 8);
        chk("t4_empty", bus.empty_out, 1);
        chk("t4_last", bus.data_out, 8'h09);

        // Wrap with simultaneous write and read.
        push(8'($urandom));
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            len_before = int'(bus.len_out);
            if ($urandom_range(0, 3) == 0 && len_before < int'(DEPTH) - 1) begin
                push(b);
            end else begin
                start_push(b);
                bus.dequeue_in = 1'b1;
                tick();
                bus.dequeue_in = 1'b0;
                chk("t5_ack", bus.ack_out, 1);
                chk("t5_len_const", bus.len_out, len_before);
                bus.data_ready = 1'b0;
                tick();
                tick();
            end
            repeat ($urandom_range(0, 2)) begin
                bus.dequeue_in = (bus.len_out > 1) ? 1'($urandom) : 1'b0;
                tick();
                bus.dequeue_in = 1'b0;
            end
        end
        bus.dequeue_in = 1'b1;
        repeat (10) tick();
        bus.dequeue_in = 1'b0;
        tick();
        chk("t5_empty", bus.empty_out, 1);
        chk("t5_sb_drained", sb.size(), 0);

        // Reset while the ack is being driven.
        start_push(8'h5A);
        tick();
        chk("t5_ack_before_rst", bus.ack_out, 1);
        reset = 1'b0;
        #1;
        chk("t5_ack_rst", bus.ack_out, 0);
        chk("t5_len_rst", bus.len_out, 0);
        chk("t5_empty_rst", bus.empty_out, 1);
        bus.data_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (4) begin
            tick();
            chk("t5_no_ack_after_rst", bus.ack_out, 0);
        end
        chk("t5_len_after_rst", bus.len_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
